// File: rtl/pwm_pkg.sv
// Shared definitions for the Dilithium point-wise-multiply datapath.
// Holds the result-collector state encoding, the Dilithium arithmetic
// constants shared with the MAU wrapper, and the PWM alu-mode code.
package pwm_pkg;

  // Collector FSM encoding (3-bit).
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_COLLECT = 3'd1;
  localparam logic [2:0] ST_FETCH   = 3'd2;
  localparam logic [2:0] ST_SHOW    = 3'd3;
  localparam logic [2:0] ST_FIN     = 3'd4;

  // Dilithium modulus and Barrett reduction constants.
  localparam logic [23:0] DIL_Q         = 24'd8380417;
  localparam logic [23:0] DIL_BARRETT_M = 24'd8396807;
  localparam int unsigned DIL_MM_N      = 23;

  // MAU alu-mode code selecting point-wise multiply.
  localparam logic [3:0] ALU_MODE_PWM = 4'b0100;

endpackage

// File: rtl/coef_sdp_ram.sv
// Simple dual-port coefficient buffer: one write port, one registered read
// port. The array itself is never reset; only the read register is.
// Ports:
//   clk, rst        clock / async active-high reset (read register only)
//   we, wr_addr, wr_data   write port
//   rd_en, rd_addr         read request; rd_data valid the next cycle
//   rd_data                registered read data, held while rd_en is low
module coef_sdp_ram #(
  parameter int unsigned DW = 24,
  parameter int unsigned N  = 256,
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pwm_result_collector.sv
// Collects N MAU point-wise-multiply results in arrival order, then drains
// them in index order over a valid/ready port. Flags results arriving
// outside collection (overflow) and results >= Q (range_err).
// Ports:
//   clk, rst                 clock / async active-high reset
//   start                    arms collection of a new polynomial (IDLE only)
//   res_valid, res_data      MAU result stream
//   out_valid, out_ready     drain handshake
//   out_data, out_idx        drained coefficient and its index
//   busy, done               status; done pulses once after the last handshake
//   count                    results captured in the current polynomial
//   overflow, range_err      sticky error flags, cleared by an accepted start
module pwm_result_collector
  import pwm_pkg::*;
#(
  parameter int unsigned     DW = 24,
  parameter int unsigned     N  = 256,
  parameter int unsigned     AW = 8,
  parameter logic [DW-1:0]   Q  = DW'(DIL_Q)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          res_valid,
  input  logic [DW-1:0] res_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_idx,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          range_err
);

  localparam logic [AW-1:0] LAST_IDX  = AW'(N - 1);
  localparam logic [AW:0]   LAST_CNT  = (AW + 1)'(N - 1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);

  logic [2:0]    state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          capture;
  logic          handshake;

  assign capture   = (state == ST_COLLECT) && res_valid;
  assign handshake = (state == ST_SHOW) && out_ready;

  assign out_valid = (state == ST_SHOW);
  assign done      = (state == ST_FIN);
  assign busy      = (state != ST_IDLE);
  assign out_idx   = rd_ptr;

  coef_sdp_ram #(
    .DW (DW),
    .N  (N),
    .AW (AW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (capture),
    .wr_addr (wr_ptr),
    .wr_data (res_data),
    .rd_en   (state == ST_FETCH),
    .rd_addr (rd_ptr),
    .rd_data (out_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      range_err <= 1'b0;
    end else begin
      // Any result outside COLLECT is dropped and flagged.
      if (res_valid && (state != ST_COLLECT)) overflow <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_COLLECT;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            range_err <= 1'b0;
            // A result coincident with start is still an overrun: the clear
            // must not hide it.
            overflow  <= res_valid;
          end
        end
        ST_COLLECT: begin
          if (res_valid) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            count  <= count + CNT_ONE;
            if (res_data >= Q) range_err <= 1'b1;
            if (count == LAST_CNT) state <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_SHOW;
        ST_SHOW: begin
          if (handshake) begin
            if (rd_ptr == LAST_IDX) begin
              state <= ST_FIN;
            end else begin
              rd_ptr <= rd_ptr + PTR_ONE;
              state  <= ST_FETCH;
            end
          end
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_result_collector.sv
// Directed self-checking bench for pwm_result_collector.
module tb_pwm_result_collector;

  localparam int N = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        res_valid;
  logic [23:0] res_data;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic [7:0]  out_idx;
  logic        busy;
  logic        done;
  logic [8:0]  count;
  logic        overflow;
  logic        range_err;

  int total = 0;
  int bad   = 0;
  logic [23:0] exp_mem [N];

  pwm_result_collector #(
    .DW (24),
    .N  (256),
    .AW (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .res_valid (res_valid),
    .res_data  (res_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .busy      (busy),
    .done      (done),
    .count     (count),
    .overflow  (overflow),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Drive exp_mem[0..N-1] into the result port, gap idle cycles between results.
  task automatic fill(input int gap);
    for (int i = 0; i < N; i++) begin
      res_valid = 1'b1;
      res_data  = exp_mem[i];
      tick();
      res_valid = 1'b0;
      if (i == 0) chk("count_after_first", count, 1);
      repeat (gap) tick();
    end
  endtask

  // mode 0: ready as soon as valid; mode 1: ready pattern 0,0,1 with hold checks.
  task automatic drain(input int mode, input int ovf_at, input int stop_at);
    int n;
    for (int k = 0; k < N; k++) begin
      n = 0;
      while (out_valid !== 1'b1 && n < 8) begin
        tick();
        n++;
      end
      chk("drain_valid", out_valid, 1);
      if (out_valid !== 1'b1) return;
      chk("drain_data", out_data, exp_mem[k]);
      chk("drain_idx", out_idx, k);
      if (k == stop_at) return;
      if (k == ovf_at) begin
        res_valid = 1'b1;
        res_data  = 24'h123456;
        tick();
        res_valid = 1'b0;
        chk("ovf_in_show", overflow, 1);
        chk("ovf_hold_data", out_data, exp_mem[k]);
        chk("ovf_hold_valid", out_valid, 1);
      end
      if (mode == 1) begin
        out_ready = 1'b0;
        repeat (2) begin
          tick();
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, exp_mem[k]);
          chk("hold_idx", out_idx, k);
        end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    chk("done_pulse", done, 1);
    chk("fin_valid", out_valid, 0);
    chk("fin_busy", busy, 1);
    tick();
    chk("done_clear", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    res_valid = 1'b0;
    res_data  = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_range_err", range_err, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_idx", out_idx, 0);
    rst = 1'b0;
    tick();

    // 1: basic fill and drain
    for (int i = 0; i < N; i++) exp_mem[i] = 24'(i);
    do_start();
    chk("s1_busy", busy, 1);
    chk("s1_count0", count, 0);
    fill(0);
    chk("s1_count_full", count, 256);
    drain(0, -1, -1);
    chk("s1_overflow", overflow, 0);
    chk("s1_range_err", range_err, 0);

    // 2: gapped input with backpressure
    for (int i = 0; i < N; i++) exp_mem[i] = 24'h100000 + 24'(i * 3);
    do_start();
    fill(2);
    chk("s2_count_full", count, 256);
    drain(1, -1, -1);
    chk("s2_overflow", overflow, 0);

    // 3: range error at index 5
    for (int i = 0; i < N; i++) exp_mem[i] = (i == 5) ? 24'd8380417 : 24'd8380416;
    do_start();
    for (int i = 0; i < N; i++) begin
      res_valid = 1'b1;
      res_data  = exp_mem[i];
      tick();
      res_valid = 1'b0;
      if (i == 4) chk("s3_range_before", range_err, 0);
      if (i == 5) chk("s3_range_after", range_err, 1);
    end
    drain(0, -1, -1);
    chk("s3_range_sticky", range_err, 1);

    // 4: overflow in IDLE and in SHOW
    res_valid = 1'b1;
    res_data  = 24'hABCDEF;
    tick();
    res_valid = 1'b0;
    chk("s4_ovf_idle", overflow, 1);
    chk("s4_idle_busy", busy, 0);
    do_start();
    chk("s4_ovf_cleared", overflow, 0);
    chk("s4_range_cleared", range_err, 0);
    for (int i = 0; i < N; i++) exp_mem[i] = 24'(i * 7);
    fill(0);
    drain(0, 10, -1);
    chk("s4_ovf_sticky", overflow, 1);

    // 5: start with res_valid in IDLE, then start while collecting
    for (int i = 0; i < N; i++) exp_mem[i] = 24'h200000 + 24'(i);
    start     = 1'b1;
    res_valid = 1'b1;
    res_data  = 24'h777777;
    tick();
    start     = 1'b0;
    res_valid = 1'b0;
    chk("s5_ovf_with_start", overflow, 1);
    chk("s5_count_dropped", count, 0);
    chk("s5_busy", busy, 1);
    for (int i = 0; i < N; i++) begin
      res_valid = 1'b1;
      res_data  = exp_mem[i];
      if (i == 100) begin
        chk("s5_count_100", count, 100);
        start = 1'b1;
      end
      tick();
      start     = 1'b0;
      res_valid = 1'b0;
      if (i == 100) chk("s5_count_101", count, 101);
    end
    chk("s5_count_full", count, 256);
    drain(0, -1, -1);
    chk("s5_ovf_sticky", overflow, 1);

    // 6: reset mid-drain, then a clean run
    for (int i = 0; i < N; i++) exp_mem[i] = 24'h300000 + 24'(i * 5);
    do_start();
    fill(0);
    drain(0, -1, 37);
    #2;
    rst = 1'b1;
    #1;
    chk("s6_rst_valid", out_valid, 0);
    chk("s6_rst_done", done, 0);
    chk("s6_rst_busy", busy, 0);
    chk("s6_rst_count", count, 0);
    chk("s6_rst_overflow", overflow, 0);
    chk("s6_rst_range", range_err, 0);
    chk("s6_rst_data", out_data, 0);
    chk("s6_rst_idx", out_idx, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("s6_idle", busy, 0);
    for (int i = 0; i < N; i++) exp_mem[i] = 24'(N - 1 - i);
    do_start();
    fill(0);
    chk("s6_count_full", count, 256);
    drain(0, -1, -1);
    chk("s6_overflow", overflow, 0);
    chk("s6_range_err", range_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_result_collector.md
Name: pwm_result_collector

Overview:
- Downstream stage of the Dilithium point-wise-multiply MAU wrapper. It consumes the MAU result stream (valid, o0) and writes N results in arrival order into an internal coefficient buffer.
- Once the buffer is full, it drains the coefficients in index order over a valid/ready output port to the next stage (NTT-inverse or memory write-back).
- It flags protocol overruns and out-of-range results (value >= q).

Parameters:
- DW, 24, coefficient width (matches MAU output width).
- N, 256, coefficients per polynomial.
- AW, 8, index width; must satisfy 2**AW == N.
- Q, 24'd8380417, Dilithium modulus used for the range check.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; arms collection of a new polynomial.
- res_valid  in  1  MAU result valid (MAU poly_valid).
- res_data  in  DW  MAU result coefficient (MAU poly_mau_o0).
- out_valid  out  1  drained coefficient valid.
- out_ready  in  1  downstream accepts coefficient.
- out_data  out  DW  drained coefficient.
- out_idx  out  AW  index of out_data (0..N-1).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last coefficient is accepted.
- count  out  AW+1  number of results captured in the current polynomial (0..N).
- overflow  out  1  sticky; a result arrived while not in COLLECT.
- range_err  out  1  sticky; a captured result had res_data >= Q.

Behaviour:
- Reset: state=IDLE; all pointers and count=0; out_valid, done, busy, overflow and range_err=0; out_data=0; out_idx=0. Buffer contents are not reset. Reset during any state aborts the operation immediately.
- States:
  - IDLE -> COLLECT on start.
  - COLLECT -> FETCH after the N-th capture.
  - FETCH -> SHOW, unconditional after 1 cycle.
  - SHOW -> FETCH on handshake when rd_ptr != N-1.
  - SHOW -> FIN on handshake when rd_ptr == N-1.
  - FIN -> IDLE, unconditional.
- start handling: a start in IDLE clears wr_ptr, rd_ptr, count, overflow and range_err. A start in any other state is ignored, with no flag.
- COLLECT:
  - Each cycle with res_valid=1 writes res_data to buf[wr_ptr], increments wr_ptr (wraps to 0 after N-1) and increments count.
  - Write latency 1: count reflects the capture in the following cycle.
  - If res_data >= Q on a capture, range_err is set; the data is still stored.
  - The capture that makes count==N moves the FSM to FETCH on the next edge.
  - Back-to-back res_valid every cycle must be accepted with no loss.
- res_valid in IDLE, FETCH, SHOW or FIN: data dropped, buffer unchanged, overflow set (sticky until the next accepted start).
- FETCH: buffer read at rd_ptr, registered read with 1-cycle latency; data lands in the out_data register.
- SHOW:
  - out_valid=1, out_idx=rd_ptr.
  - out_data and out_idx stay stable until out_valid&&out_ready.
  - On handshake with rd_ptr != N-1: rd_ptr increments.
  - out_ready may stay low indefinitely; no timeout.
  - Peak drain throughput is 1 coefficient per 2 cycles.
- FIN: done=1 for exactly one cycle; out_valid=0.
- busy = (state != IDLE).
- Simultaneous events:
  - start together with res_valid in IDLE: the FSM enters COLLECT, the sample is dropped and overflow is set after the clear. The clear must not mask this flag.
  - out_ready without out_valid has no effect.

Decomposition:
- pwm_pkg holds:
  - the state encoding (IDLE, COLLECT, FETCH, SHOW, FIN; 3-bit);
  - the Dilithium constants shared with the MAU wrapper: Q=8380417, Barrett M=8396807, MM N=23;
  - the PWM alu-mode code 4'b0100.
- One sub-module, coef_sdp_ram: simple dual-port, one write port and one registered-read port, DW x N, no reset on the array.
- The FSM, counters and flags stay in pwm_result_collector.

Test Plan:
1. Basic fill and drain: start; drive res_data=i for i=0..255 on consecutive cycles with out_ready=1 -> count reaches 256; 256 handshakes with out_data==out_idx==i; done pulses once; busy falls the cycle after done; no flags set.
2. Gapped input with backpressure: res_valid 1-of-3 cycles; out_ready toggling 0,0,1 -> order preserved; out_data and out_idx held stable while out_ready=0.
3. Range error: capture res_data=24'd8380417 at index 5 and 24'd8380416 elsewhere -> range_err=1 after index 5; the stored value drains unmodified at index 5.
4. Overflow: pulse res_valid in IDLE, then during SHOW -> overflow=1 both times; buffer unchanged; the next start clears it.
5. Start while busy: start in COLLECT at count=100 -> ignored; count continues to 256.
6. Reset mid-drain: assert rst at out_idx=37 -> all outputs 0 asynchronously; after deassert, a new start and fill works as in scenario 1.
